// File: rtl/dual_issue_ctrl_pkg.sv
// Shared types and defaults for the dual-issue pipeline controller.
// Pure declarations: no logic, no latency.
// No flow control of its own.
package dual_issue_ctrl_pkg;

    localparam int REG_ADDR_W_DEF = 5;
    localparam int CNT_W_DEF      = 16;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_SPLIT  = 2'd1,
        ST_BUBBLE = 2'd2
    } issue_state_t;

endpackage

// File: rtl/dual_issue_ctrl_hazard_cmp.sv
// Intra-pair RAW / serialisation conflict and EX load-use detection.
// Combinational, zero latency.
// No flow control; results are qualified by the caller.
module hazard_cmp #(
    parameter int REG_ADDR_W = 5
) (
    input  logic [1:0]            id_valid,
    input  logic                  id_unicorn,
    input  logic [REG_ADDR_W-1:0] id_rd0,
    input  logic [REG_ADDR_W-1:0] id_rs1_0,
    input  logic [REG_ADDR_W-1:0] id_rs2_0,
    input  logic [REG_ADDR_W-1:0] id_rs1_1,
    input  logic [REG_ADDR_W-1:0] id_rs2_1,
    input  logic                  ex_load_valid,
    input  logic [REG_ADDR_W-1:0] ex_load_rd,
    output logic                  pair_conflict,
    output logic                  load_use
);

    logic pair_raw;
    logic lu_lane0;
    logic lu_lane1;

    // x0 is never a real dependency
    assign pair_raw      = (id_rd0 != '0) && ((id_rd0 == id_rs1_1) || (id_rd0 == id_rs2_1));
    assign pair_conflict = (id_valid == 2'b11) && (id_unicorn || pair_raw);

    assign lu_lane0 = id_valid[0] && ((ex_load_rd == id_rs1_0) || (ex_load_rd == id_rs2_0));
    assign lu_lane1 = id_valid[1] && ((ex_load_rd == id_rs1_1) || (ex_load_rd == id_rs2_1));
    assign load_use = ex_load_valid && (ex_load_rd != '0) && (lu_lane0 || lu_lane1);

endmodule

// File: rtl/dual_issue_ctrl.sv
// Issue control for a two-lane in-order pipe: splits conflicting pairs, inserts load-use bubbles.
// Stall/flush/issue are combinational (zero latency); event counters update one cycle later.
// mem_busy holds everything; a branch redirect overrides the hold and clears both lanes.
module dual_issue_ctrl
    import dual_issue_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            id_valid,
    input  logic                  id_unicorn,
    input  logic [REG_ADDR_W-1:0] id_rd0,
    input  logic [REG_ADDR_W-1:0] id_rs1_1,
    input  logic [REG_ADDR_W-1:0] id_rs2_1,
    input  logic [REG_ADDR_W-1:0] id_rs1_0,
    input  logic [REG_ADDR_W-1:0] id_rs2_0,
    input  logic                  ex_load_valid,
    input  logic [REG_ADDR_W-1:0] ex_load_rd,
    input  logic                  mem_busy,
    input  logic                  br_flush,
    input  logic                  br_lane,
    output logic                  ifid_stall,
    output logic [1:0]            idex_stall,
    output logic [1:0]            idex_flush,
    output logic [1:0]            issue_lane,
    output logic [CNT_W-1:0]      split_cnt,
    output logic [CNT_W-1:0]      bubble_cnt
);

    issue_state_t state;
    issue_state_t state_nxt;
    logic         pair_conflict;
    logic         load_use;
    logic         br_redirect;
    logic         split_evt;
    logic         bubble_evt;

    hazard_cmp #(.REG_ADDR_W(REG_ADDR_W)) u_hazard_cmp (
        .id_valid      (id_valid),
        .id_unicorn    (id_unicorn),
        .id_rd0        (id_rd0),
        .id_rs1_0      (id_rs1_0),
        .id_rs2_0      (id_rs2_0),
        .id_rs1_1      (id_rs1_1),
        .id_rs2_1      (id_rs2_1),
        .ex_load_valid (ex_load_valid),
        .ex_load_rd    (ex_load_rd),
        .pair_conflict (pair_conflict),
        .load_use      (load_use)
    );

    // Both ID lanes are younger than a branch in either EX lane, so the lane does not matter.
    assign br_redirect = br_flush && ((br_lane == 1'b0) || (br_lane == 1'b1));

    always_comb begin
        state_nxt  = state;
        ifid_stall = 1'b0;
        idex_stall = 2'b00;
        idex_flush = 2'b00;
        issue_lane = 2'b00;
        split_evt  = 1'b0;
        bubble_evt = 1'b0;
        if (!rst_n) begin
            idex_flush = 2'b11;
            state_nxt  = ST_RUN;
        end else if (br_redirect) begin
            idex_flush = 2'b11;
            state_nxt  = ST_RUN;
        end else if (mem_busy) begin
            ifid_stall = 1'b1;
            idex_stall = 2'b11;
        end else begin
            case (state)
                ST_SPLIT: begin
                    issue_lane = 2'b10;
                    idex_flush = 2'b01;
                    state_nxt  = ST_RUN;
                end
                default: begin
                    // BUBBLE re-evaluates like RUN but never bubbles twice for the same load
                    if (state == ST_RUN && load_use) begin
                        ifid_stall = 1'b1;
                        idex_flush = 2'b11;
                        state_nxt  = ST_BUBBLE;
                        bubble_evt = 1'b1;
                    end else if (pair_conflict) begin
                        ifid_stall = 1'b1;
                        issue_lane = 2'b01;
                        idex_flush = 2'b10;
                        state_nxt  = ST_SPLIT;
                        split_evt  = 1'b1;
                    end else begin
                        issue_lane = id_valid;
                        idex_flush = ~id_valid;
                        state_nxt  = ST_RUN;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_RUN;
            split_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (split_evt && (split_cnt != '1)) begin
                split_cnt <= split_cnt + CNT_W'(1);
            end
            if (bubble_evt && (bubble_cnt != '1)) begin
                bubble_cnt <= bubble_cnt + CNT_W'(1);
            end
        end
    end

endmodule
